// File: rtl/avg_word_packer_pkg.sv
// avg_word_packer_pkg: shared sizing constants for the averaged-byte word packer.
package avg_word_packer_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int LANES     = 4;
    localparam int WORD_W    = 8 * LANES;
    localparam int LVL_W     = 5;
endpackage

// File: rtl/avg_word_fifo.sv
// avg_word_fifo: synchronous FIFO whose head word, valid and level are all registered.
module avg_word_fifo
    import avg_word_packer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              ready,
    output logic              valid,
    output logic [WORD_W-1:0] data,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              pop, push_ok;
    logic [LVL_W-1:0]  rem;

    assign full    = level == LVL_W'(DEPTH);
    assign empty   = level == '0;
    assign pop     = valid & ready;
    assign push_ok = push & (~full | pop);
    assign rem     = level - LVL_W'(pop);

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= push_data;

    // When nothing older survives the pop, the incoming word becomes the head directly.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            data   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_ok);
            rd_ptr <= rd_ptr + PW'(pop);
            level  <= rem + LVL_W'(push_ok);
            valid  <= (rem + LVL_W'(push_ok)) != '0;
            data   <= rem == '0 ? (push_ok ? push_data : data) : mem[rd_ptr + PW'(pop)];
        end
endmodule

// File: rtl/avg_word_packer.sv
// avg_word_packer: packs averaged bytes little-endian into 32-bit words and queues them.
module avg_word_packer
    import avg_word_packer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_data_de,
    input  logic [7:0]        data_in,
    input  logic              i_flush,
    input  logic              i_clr,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_overflow
);
    logic [1:0]        cnt;
    logic [WORD_W-1:0] part, cur;
    logic              push, full, empty, drop;

    // Partial word keeps unfilled lanes at zero, so a flush needs no extra masking.
    assign cur  = part | (i_data_de ? WORD_W'(data_in) << {cnt, 3'b000} : '0);
    assign push = (i_data_de & (cnt == 2'd3)) | (i_flush & ((cnt != 2'd0) | i_data_de));
    assign drop = push & full & ~(~empty & i_ready);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt        <= '0;
            part       <= '0;
            o_overflow <= 1'b0;
        end else begin
            cnt        <= push ? 2'd0 : cnt + {1'b0, i_data_de};
            part       <= push ? '0 : cur;
            o_overflow <= drop | (o_overflow & ~i_clr);
        end

    avg_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (cur),
        .ready     (i_ready),
        .valid     (o_valid),
        .data      (o_data),
        .level     (o_level),
        .full      (full),
        .empty     (empty)
    );
endmodule

// File: tb/tb_avg_word_packer.sv
// tb_avg_word_packer: directed vector table plus multi-cycle sequences for the word packer.
module tb_avg_word_packer;
    logic        clk, rst_n, i_data_de, i_flush, i_clr, i_ready;
    logic [7:0]  data_in;
    logic        o_valid, o_overflow;
    logic [31:0] o_data;
    logic [4:0]  o_level;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       de;
        logic [7:0] d;
        logic       fl, cl, rdy, ev;
        logic [31:0] ed;
        logic [4:0]  el;
    } vec_t;

    vec_t        vec [18];
    logic [31:0] q [$];
    logic [31:0] held;
    logic        mon = 1'b0, tg = 1'b0, stalled = 1'b0;

    avg_word_packer #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data_de  (i_data_de),
        .data_in    (data_in),
        .i_flush    (i_flush),
        .i_clr      (i_clr),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic de, input logic [7:0] d, input logic fl, input logic rdy,
                                input logic ev, input logic [31:0] ed, input logic [4:0] el);
        vec_t v;
        v.de = de; v.d = d; v.fl = fl; v.cl = 1'b0; v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the streaming monitor samples just before the rising edge.
    task automatic step(input logic de, input logic [7:0] d, input logic fl, input logic cl, input logic rdy);
        @(negedge clk);
        i_data_de = de; data_in = d; i_flush = fl; i_clr = cl;
        i_ready = mon ? tg : rdy;
        tg = ~tg;
        #1;
        if (mon) begin
            if (stalled) begin
                chk("stall_valid", {31'b0, o_valid}, 32'd1);
                chk("stall_hold", o_data, held);
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) chk("unexpected_pop", {31'b0, o_valid}, 32'd0);
                else chk("order", o_data, q.pop_front());
            end
            stalled = o_valid && !i_ready;
            held    = o_data;
        end
        @(posedge clk);
        #1;
        i_data_de = 1'b0; i_flush = 1'b0; i_clr = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input logic rdy);
        for (int b = 0; b < 4; b++) step(1'b1, w[8*b +: 8], 1'b0, 1'b0, rdy);
    endtask

    initial begin
        rst_n = 1'b0; i_data_de = 1'b0; data_in = '0; i_flush = 1'b0; i_clr = 1'b0; i_ready = 1'b0;
        vec[0]  = mk(1, 8'h11, 0, 1, 0, 32'h0,        5'd0);
        vec[1]  = mk(1, 8'h22, 0, 1, 0, 32'h0,        5'd0);
        vec[2]  = mk(1, 8'h33, 0, 1, 0, 32'h0,        5'd0);
        vec[3]  = mk(1, 8'h44, 0, 1, 1, 32'h44332211, 5'd1);
        vec[4]  = mk(1, 8'hAA, 0, 1, 0, 32'h0,        5'd0);
        vec[5]  = mk(1, 8'hBB, 0, 1, 0, 32'h0,        5'd0);
        vec[6]  = mk(0, 8'h00, 1, 1, 1, 32'h0000BBAA, 5'd1);
        vec[7]  = mk(1, 8'h01, 0, 0, 1, 32'h0000BBAA, 5'd1);
        vec[8]  = mk(0, 8'h00, 1, 0, 1, 32'h0000BBAA, 5'd2);
        vec[9]  = mk(0, 8'h00, 0, 1, 1, 32'h00000001, 5'd1);
        vec[10] = mk(0, 8'h00, 1, 1, 0, 32'h0,        5'd0);
        vec[11] = mk(1, 8'h5A, 1, 0, 1, 32'h0000005A, 5'd1);
        vec[12] = mk(0, 8'hFF, 0, 1, 0, 32'h0,        5'd0);
        vec[13] = mk(1, 8'h01, 0, 0, 0, 32'h0,        5'd0);
        vec[14] = mk(1, 8'h02, 0, 0, 0, 32'h0,        5'd0);
        vec[15] = mk(1, 8'h03, 0, 0, 0, 32'h0,        5'd0);
        vec[16] = mk(1, 8'h04, 1, 0, 1, 32'h04030201, 5'd1);
        vec[17] = mk(0, 8'hFF, 1, 1, 0, 32'h0,        5'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_level", {27'b0, o_level}, 32'd0);
        chk("rst_ovf", {31'b0, o_overflow}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vec[i].de, vec[i].d, vec[i].fl, vec[i].cl, vec[i].rdy);
            chk($sformatf("vec%0d_valid", i), {31'b0, o_valid}, {31'b0, vec[i].ev});
            chk($sformatf("vec%0d_level", i), {27'b0, o_level}, {27'b0, vec[i].el});
            chk($sformatf("vec%0d_ovf", i), {31'b0, o_overflow}, 32'd0);
            if (vec[i].ev) chk($sformatf("vec%0d_data", i), o_data, vec[i].ed);
        end

        // fill past capacity with the consumer stalled
        for (int i = 0; i < 9; i++) push_word(32'hC0DE_0000 | i, 1'b0);
        chk("fill_level", {27'b0, o_level}, 32'd8);
        chk("fill_ovf", {31'b0, o_overflow}, 32'd1);
        chk("fill_head", o_data, 32'hC0DE_0000);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", {31'b0, o_overflow}, 32'd0);
        chk("clr_level", {27'b0, o_level}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), o_data, 32'hC0DE_0000 | i);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("drain_level", {27'b0, o_level}, 32'd0);
        chk("drain_valid", {31'b0, o_valid}, 32'd0);

        // full FIFO, pop coincides with the completing byte
        for (int i = 0; i < 8; i++) push_word(32'hB0B0_0000 | i, 1'b0);
        chk("full_level", {27'b0, o_level}, 32'd8);
        step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hE4, 1'b0, 1'b0, 1'b1);
        chk("simul_level", {27'b0, o_level}, 32'd8);
        chk("simul_ovf", {31'b0, o_overflow}, 32'd0);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("simul_out%0d", i), o_data, i < 8 ? (32'hB0B0_0000 | i) : 32'hE4E3E2E1);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("simul_empty", {31'b0, o_valid}, 32'd0);

        // streaming with i_ready toggling every cycle
        mon = 1'b1; stalled = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] w;
            w = $urandom;
            push_word(w, 1'b0);
            q.push_back(w);
        end
        mon = 1'b0;
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            #1;
            if (o_valid) chk("bp_drain", o_data, q.pop_front());
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("bp_left", q.size(), 32'd0);
        chk("bp_level", {27'b0, o_level}, 32'd0);
        chk("bp_ovf", {31'b0, o_overflow}, 32'd0);

        // reset with stored words and a partial word pending
        for (int i = 0; i < 3; i++) push_word(32'h0D0D_0000 | i, 1'b0);
        step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", {27'b0, o_level}, 32'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("async_rst_level", {27'b0, o_level}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        push_word(32'h64636261, 1'b0);
        chk("post_rst_valid", {31'b0, o_valid}, 32'd1);
        chk("post_rst_data", o_data, 32'h64636261);
        chk("post_rst_level", {27'b0, o_level}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
